stack_arbiter: RTL and testbench
================================

// Module: stack_arbiter
// PURPOSE
//  Shares one 32x8 edge-triggered stack between two requesters: requester 0 is the core datapath, requester 1 is the call/return unit.
//  Arbitrates round-robin and turns each granted request into a single clean push or pop pulse.
//  Tracks depth so overflow and underflow are reported as errors, never forwarded to the stack.
//  Drains the non-resettable stack after reset, so software always starts from an empty stack.
// PARAMETERS
//  DW        8   data width; matches the stack word
//  CAP       31  usable entries; the stack reserves entry 0, so 32 words give 31
//  DRAIN     31  pop pulses issued after reset release; must be >= CAP
// PORTS
//  clk       in   1    system clock; all logic on rising edge
//  rst_n     in   1    asynchronous, active-low reset
//  req0      in   1    requester 0 request; held high until ack0
//  op0       in   2    00 PUSH, 01 POP, 10 PEEK, 11 reserved
//  din0      in   DW   push data, requester 0
//  ack0      out  1    one-cycle completion strobe, requester 0
//  err0      out  1    valid with ack0; op was refused
//  req1/op1/din1/ack1/err1  same set of signals for requester 1
//  rd_data   out  DW   top of stack after the op; valid with ack0/ack1
//  ready     out  1    high when idle and accepting requests; low while draining
//  depth     out  5    current entry count, 0..CAP
//  empty     out  1    depth==0
//  full      out  1    depth==CAP
//  stk_din   out  DW   to stack d_in; registered, stable around the pulse
//  stk_push  out  1    to stack push; registered, one-cycle pulse
//  stk_pop   out  1    to stack pop; registered, one-cycle pulse
//  stk_dout  in   DW   from stack d_out
// BEHAVIOUR
//  Reset values (asynchronous): every output 0, state DRAIN_HI, drain count 0, rr_last=1.
//  Drain sequence
//   - DRAIN_HI asserts stk_pop; DRAIN_LO deasserts it. This gives a falling edge between pulses.
//   - After DRAIN pulses, go to IDLE with ready=1 and depth=0 (2*DRAIN cycles total).
//   - Requests are ignored while draining.
//  IDLE arbitration
//   - req0 and req1 are sampled only in IDLE.
//   - One requester pending: it wins.
//   - Both pending: the one not equal to rr_last wins, then rr_last is updated.
//   - Winner's op and din are latched; ready drops the next cycle.
//  Error check in IDLE, against current depth
//   - PUSH with full, POP with empty, or op 11 marks the request as an error.
//  ISSUE (one cycle)
//   - Valid PUSH: stk_push=1, stk_din=latched din.
//   - Valid POP: stk_pop=1.
//   - PEEK or error: no pulse.
//  SETTLE (one cycle)
//   - All pulses low; the stack output settles.
//  DONE (one cycle)
//   - ackN=1 for the winner; errN=1 if the request was refused.
//   - rd_data <= stk_dout.
//   - depth +1 on valid PUSH, -1 on valid POP.
//   - Next state IDLE.
//  Latency: request sampled in IDLE at cycle t -> ack at t+3, fixed for every op including errors.
//   Next grant no earlier than t+4.
//  Stack interface rules
//   - stk_push and stk_pop are never high together and never high in consecutive cycles.
//   - stk_din is stable from ISSUE through SETTLE.
//  Protocol and reset cases
//   - A requester that drops req before ack loses nothing; the op still completes and acks.
//   - Reset mid-op aborts immediately with all outputs 0; the drain sequence restores a consistent depth.
//   - depth never wraps: bounds are checked before any pulse.
// STRUCTURE
//  Package stack_arbiter_pkg holds:
//   - typedef enum logic [1:0] stk_op_e {OP_PUSH, OP_POP, OP_PEEK, OP_RSVD}
//   - typedef enum state_e {DRAIN_HI, DRAIN_LO, IDLE, ISSUE, SETTLE, DONE}
//   - localparams STK_DW=8, STK_CAP=31
//  Sub-module rr_arb2 (2-way round-robin: req[1:0], update, gnt[1:0], with the rr_last flop inside).
//  FSM, depth counter and drain counter stay in the top level.
// TESTING
//  1 Reset release: ready=0 for 62 cycles, exactly 31 stk_pop pulses each separated by a low cycle, then ready=1, depth=0.
//  2 req0 PUSH 8'hA5 -> stk_push pulse with stk_din=A5; ack0 at t+3, rd_data=A5, depth=1.
//    Then req1 POP -> ack1, depth=0.
//  3 req0 and req1 both PUSH in the same IDLE cycle -> req0 served first, req1 next.
//    Repeat -> req1 served first; grants alternate.
//  4 POP when empty -> ack0 with err0=1, no stk_pop pulse, depth stays 0.
//    31 PUSHes, then a 32nd -> err, no stk_push pulse, full=1.
//  5 PEEK after pushing 11,22 -> rd_data=22, depth unchanged, no pulses; op 11 -> err with depth unchanged.
//  6 rst_n low during SETTLE of a PUSH -> outputs 0 at once, no ack; after release, drain runs, then normal ops resume.

Source files
------------

// File: rtl/stack_arbiter_pkg.sv
// Shared types and constants for the two-requester stack arbiter.
// The refusal rule lives here so the top level and any future user agree on it.
package stack_arbiter_pkg;

  localparam int STK_DW  = 8;
  localparam int STK_CAP = 31;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } stk_op_e;

  typedef enum logic [2:0] {
    DRAIN_HI,
    DRAIN_LO,
    IDLE,
    ISSUE,
    SETTLE,
    DONE
  } state_e;

  // A request is refused when it would over/underflow or uses the reserved code.
  function automatic logic op_refused(input stk_op_e op, input logic is_full,
                                      input logic is_empty);
    return (op == OP_RSVD) || ((op == OP_PUSH) && is_full) ||
           ((op == OP_POP) && is_empty);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last winner under contention loses the next tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic rr_last_reg;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last_reg ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Only a contended grant moves the pointer; a lone requester leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_reg <= 1'b1;
    end else if (update && (req == 2'b11)) begin
      rr_last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto one edge-triggered stack, issuing clean push/pop pulses,
// tracking depth to refuse over/underflow, and draining the stack after every reset.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int DW    = STK_DW,
  parameter int CAP   = STK_CAP,
  parameter int DRAIN = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [1:0]    op0,
  input  logic [DW-1:0] din0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic [1:0]    op1,
  input  logic [DW-1:0] din1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rd_data,
  output logic          ready,
  output logic [4:0]    depth,
  output logic          empty,
  output logic          full,
  output logic [DW-1:0] stk_din,
  output logic          stk_push,
  output logic          stk_pop,
  input  logic [DW-1:0] stk_dout
);

  localparam int             DCW        = $clog2(DRAIN + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN);
  localparam logic [4:0]     CAP_D      = 5'(CAP);

  state_e          state_reg, state_next;
  logic [DCW-1:0]  drain_cnt_reg;
  logic            win_reg;
  stk_op_e         op_reg;
  logic            refuse_reg;

  logic [1:0]      ack_reg, ack_next;
  logic [1:0]      err_reg, err_next;
  logic [DW-1:0]   rd_data_reg;
  logic            ready_reg, ready_next;
  logic [4:0]      depth_reg, depth_next;
  logic            empty_reg, full_reg;
  logic [DW-1:0]   stk_din_reg;
  logic            push_reg, push_next;
  logic            pop_reg, pop_next;

  logic [1:0]      gnt;
  logic            grant;
  logic            win_sel;
  stk_op_e         win_op;
  logic [DW-1:0]   win_din;
  logic            win_refuse;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1, req0}),
    .update (state_reg == IDLE),
    .gnt    (gnt)
  );

  always_comb begin
    win_sel    = gnt[1];
    win_op     = win_sel ? stk_op_e'(op1) : stk_op_e'(op0);
    win_din    = win_sel ? din1 : din0;
    win_refuse = op_refused(win_op, depth_reg == CAP_D, depth_reg == 5'd0);
    grant      = (state_reg == IDLE) && (gnt != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DRAIN_HI;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DRAIN_HI: state_next = DRAIN_LO;
      DRAIN_LO: state_next = (drain_cnt_reg == DRAIN_LAST) ? IDLE : DRAIN_HI;
      IDLE:     state_next = grant ? ISSUE : IDLE;
      ISSUE:    state_next = SETTLE;
      SETTLE:   state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = DRAIN_HI;
    endcase
  end

  // Output decode yields next values; every stack-facing signal is then registered.
  always_comb begin
    push_next  = grant && !win_refuse && (win_op == OP_PUSH);
    pop_next   = (state_reg == DRAIN_HI) || (grant && !win_refuse && (win_op == OP_POP));
    ready_next = (state_next == IDLE);
    depth_next = depth_reg;
    if ((state_reg == DRAIN_HI) || (state_reg == DRAIN_LO)) begin
      depth_next = 5'd0;
    end else if ((state_reg == SETTLE) && !refuse_reg) begin
      if (op_reg == OP_PUSH) begin
        depth_next = depth_reg + 5'd1;
      end else if (op_reg == OP_POP) begin
        depth_next = depth_reg - 5'd1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign ack_next[gi] = (state_reg == SETTLE) && (win_reg == (gi == 1));
    assign err_next[gi] = ack_next[gi] && refuse_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_reg <= '0;
      win_reg       <= 1'b0;
      op_reg        <= OP_PUSH;
      refuse_reg    <= 1'b0;
      ack_reg       <= 2'b00;
      err_reg       <= 2'b00;
      rd_data_reg   <= '0;
      ready_reg     <= 1'b0;
      depth_reg     <= 5'd0;
      empty_reg     <= 1'b0;
      full_reg      <= 1'b0;
      stk_din_reg   <= '0;
      push_reg      <= 1'b0;
      pop_reg       <= 1'b0;
    end else begin
      if (state_reg == DRAIN_HI) begin
        drain_cnt_reg <= drain_cnt_reg + 1'b1;
      end
      if (grant) begin
        win_reg    <= win_sel;
        op_reg     <= win_op;
        refuse_reg <= win_refuse;
      end
      if (push_next) begin
        stk_din_reg <= win_din;
      end
      if (state_reg == SETTLE) begin
        rd_data_reg <= stk_dout;
      end
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      ready_reg <= ready_next;
      depth_reg <= depth_next;
      empty_reg <= (depth_next == 5'd0);
      full_reg  <= (depth_next == CAP_D);
      push_reg  <= push_next;
      pop_reg   <= pop_next;
    end
  end

  assign ack0     = ack_reg[0];
  assign ack1     = ack_reg[1];
  assign err0     = err_reg[0];
  assign err1     = err_reg[1];
  assign rd_data  = rd_data_reg;
  assign ready    = ready_reg;
  assign depth    = depth_reg;
  assign empty    = empty_reg;
  assign full     = full_reg;
  assign stk_din  = stk_din_reg;
  assign stk_push = push_reg;
  assign stk_pop  = pop_reg;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: table vectors, contention and reset sequences, and random
// traffic checked against a queue-based stack model with a behavioural stack attached.
module tb_stack_arbiter;
  import stack_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       ack0, err0, ack1, err1, ready, empty, full, stk_push, stk_pop;
  logic [7:0] rd_data, stk_din, stk_dout;
  logic [4:0] depth;

  always #5 clk = ~clk;

  stack_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .din0(din0), .ack0(ack0), .err0(err0),
    .req1(req1), .op1(op1), .din1(din1), .ack1(ack1), .err1(err1),
    .rd_data(rd_data), .ready(ready), .depth(depth), .empty(empty), .full(full),
    .stk_din(stk_din), .stk_push(stk_push), .stk_pop(stk_pop), .stk_dout(stk_dout)
  );

  // Behavioural 32x8 stack, entry 0 reserved, not reset; starts mid-way to prove the drain.
  logic [7:0] stk_mem [32];
  logic [4:0] sp = 5'd19;
  assign stk_dout = stk_mem[sp];
  always @(posedge clk) begin
    if (stk_push) begin
      sp <= sp + 5'd1;
      stk_mem[sp + 5'd1] <= stk_din;
    end else if (stk_pop && sp != 5'd0) begin
      sp <= sp - 5'd1;
    end
  end

  int npush = 0, npop = 0, viol = 0;
  bit prev_pulse = 1'b0, prev_push = 1'b0;
  logic [7:0] prev_din = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stk_push) npush++;
      if (stk_pop) npop++;
      if (stk_push && stk_pop) viol++;
      if ((stk_push || stk_pop) && prev_pulse) viol++;
      if (prev_push && stk_din != prev_din) viol++;
    end
    prev_pulse = rst_n && (stk_push || stk_pop);
    prev_push  = rst_n && stk_push;
    prev_din   = stk_din;
  end

  int passed = 0, total = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference model: stack contents as a queue, plus the contention pointer.
  logic [7:0] q[$];
  bit rr_last_m = 1'b1;
  function automatic bit m_apply(input logic [1:0] op, input logic [7:0] d);
    bit e;
    e = (op == 2'b11) || (op == 2'b00 && q.size() == 31) || (op == 2'b01 && q.size() == 0);
    if (!e && op == 2'b00) q.push_back(d);
    if (!e && op == 2'b01) void'(q.pop_back());
    return e;
  endfunction

  task automatic wait_ready();
    for (int n = 0; n < 300; n++) begin
      if (ready) return;
      @(posedge clk); #1;
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic do_op(input bit who, input logic [1:0] op, input logic [7:0] d,
                       output bit e, output logic [7:0] rd, output int lat,
                       output int np, output int npp);
    int bp, bpp;
    wait_ready();
    bp = npush; bpp = npop;
    if (!who) begin req0 = 1'b1; op0 = op; din0 = d; end
    else      begin req1 = 1'b1; op1 = op; din1 = d; end
    lat = -1; e = 1'b0; rd = 8'h00;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (who ? ack1 : ack0) begin
        lat = n; e = who ? err1 : err0; rd = rd_data;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    np = npush - bp; npp = npop - bpp;
    $display("op who=%0d op=%0d din=%02h -> lat=%0d err=%0d rd=%02h depth=%0d push=%0d pop=%0d",
             who, op, d, lat, e, rd, depth, np, npp);
  endtask

  // Single op checked against the model.
  task automatic model_op(input string tag, input bit who, input logic [1:0] op, input logic [7:0] d);
    bit e, ee; logic [7:0] rd; int lat, np, npp;
    do_op(who, op, d, e, rd, lat, np, npp);
    ee = m_apply(op, d);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_err"}, int'(e), int'(ee));
    chk({tag, "_depth"}, int'(depth), q.size());
    chk({tag, "_push"}, np, (op == 2'b00 && !ee) ? 1 : 0);
    chk({tag, "_pop"}, npp, (op == 2'b01 && !ee) ? 1 : 0);
    chk({tag, "_full"}, int'(full), (q.size() == 31) ? 1 : 0);
    if (q.size() > 0) chk({tag, "_rd"}, int'(rd), int'(q[$]));
  endtask

  task automatic run_pair(input string tag, input logic [1:0] o0, input logic [7:0] d0,
                          input logic [1:0] o1, input logic [7:0] d1);
    int l0, l1, bp, bpp, exp_np, exp_npp;
    bit e0, e1, ee0, ee1, rv0, rv1, w;
    logic [7:0] r0, r1, er0, er1;
    l0 = -1; l1 = -1; e0 = 0; e1 = 0; r0 = 0; r1 = 0; er0 = 0; er1 = 0;
    wait_ready();
    bp = npush; bpp = npop;
    req0 = 1'b1; op0 = o0; din0 = d0; req1 = 1'b1; op1 = o1; din1 = d1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack0 && l0 < 0) begin l0 = n; e0 = err0; r0 = rd_data; req0 = 1'b0; end
      if (ack1 && l1 < 0) begin l1 = n; e1 = err1; r1 = rd_data; req1 = 1'b0; end
      if (l0 > 0 && l1 > 0) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    w = !rr_last_m;
    rr_last_m = w;
    if (!w) begin
      ee0 = m_apply(o0, d0); rv0 = q.size() > 0; if (rv0) er0 = q[$];
      ee1 = m_apply(o1, d1); rv1 = q.size() > 0; if (rv1) er1 = q[$];
    end else begin
      ee1 = m_apply(o1, d1); rv1 = q.size() > 0; if (rv1) er1 = q[$];
      ee0 = m_apply(o0, d0); rv0 = q.size() > 0; if (rv0) er0 = q[$];
    end
    exp_np  = ((o0 == 2'b00 && !ee0) ? 1 : 0) + ((o1 == 2'b00 && !ee1) ? 1 : 0);
    exp_npp = ((o0 == 2'b01 && !ee0) ? 1 : 0) + ((o1 == 2'b01 && !ee1) ? 1 : 0);
    $display("pair op0=%0d/%02h op1=%0d/%02h -> lat0=%0d lat1=%0d err=%0d%0d depth=%0d",
             o0, d0, o1, d1, l0, l1, e0, e1, depth);
    chk({tag, "_lat0"}, l0, w ? 7 : 3);
    chk({tag, "_lat1"}, l1, w ? 3 : 7);
    chk({tag, "_err0"}, int'(e0), int'(ee0));
    chk({tag, "_err1"}, int'(e1), int'(ee1));
    if (rv0) chk({tag, "_rd0"}, int'(r0), int'(er0));
    if (rv1) chk({tag, "_rd1"}, int'(r1), int'(er1));
    chk({tag, "_depth"}, int'(depth), q.size());
    chk({tag, "_push"}, npush - bp, exp_np);
    chk({tag, "_pop"}, npop - bpp, exp_npp);
  endtask

  task automatic check_drain(input string tag);
    int cyc, pops, adj;
    bit prev;
    cyc = 0; pops = 0; adj = 0; prev = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      cyc = n;
      if (stk_pop) begin pops++; if (prev) adj++; end
      prev = stk_pop;
      if (ready) break;
    end
    q.delete();
    $display("drain %s: cycles=%0d pops=%0d depth=%0d empty=%0d", tag, cyc, pops, depth, empty);
    chk({tag, "_cycles"}, cyc, 62);
    chk({tag, "_pops"}, pops, 31);
    chk({tag, "_adjacent"}, adj, 0);
    chk({tag, "_depth"}, int'(depth), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_sp"}, int'(sp), 0);
  endtask

  typedef struct {
    bit         who;
    logic [1:0] op;
    logic [7:0] din;
    bit         exp_err;
    int         exp_depth;
    logic [7:0] exp_rd;
    bit         chk_rd;
    int         exp_push;
    int         exp_pop;
  } vec_t;
  vec_t tbl[9];

  initial begin
    bit e; logic [7:0] rd; int lat, np, npp;
    logic [1:0] ro0, ro1;

    tbl[0] = '{0, 2'b00, 8'hA5, 0, 1, 8'hA5, 1, 1, 0};
    tbl[1] = '{1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 0, 1};
    tbl[2] = '{0, 2'b01, 8'h00, 1, 0, 8'h00, 0, 0, 0};
    tbl[3] = '{1, 2'b00, 8'h11, 0, 1, 8'h11, 1, 1, 0};
    tbl[4] = '{0, 2'b00, 8'h22, 0, 2, 8'h22, 1, 1, 0};
    tbl[5] = '{1, 2'b10, 8'h00, 0, 2, 8'h22, 1, 0, 0};
    tbl[6] = '{0, 2'b11, 8'h5A, 1, 2, 8'h22, 1, 0, 0};
    tbl[7] = '{1, 2'b01, 8'h00, 0, 1, 8'h11, 1, 0, 1};
    tbl[8] = '{0, 2'b01, 8'h00, 0, 0, 8'h00, 0, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", int'({ack0, ack1, err0, err1, ready, stk_push, stk_pop, empty, full}), 0);
    chk("rst_depth", int'(depth), 0);
    check_drain("drain1");

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].who, tbl[i].op, tbl[i].din, e, rd, lat, np, npp);
      void'(m_apply(tbl[i].op, tbl[i].din));
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_err", i), int'(e), int'(tbl[i].exp_err));
      chk($sformatf("vec%0d_depth", i), int'(depth), tbl[i].exp_depth);
      chk($sformatf("vec%0d_empty", i), int'(empty), (tbl[i].exp_depth == 0) ? 1 : 0);
      chk($sformatf("vec%0d_push", i), np, tbl[i].exp_push);
      chk($sformatf("vec%0d_pop", i), npp, tbl[i].exp_pop);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), int'(rd), int'(tbl[i].exp_rd));
    end

    run_pair("pairA", 2'b00, 8'h33, 2'b00, 8'h44);
    run_pair("pairB", 2'b00, 8'h55, 2'b00, 8'h66);

    while (q.size() < 31) model_op("fill", q.size() % 2 == 1, 2'b00, 8'($urandom_range(1, 255)));
    model_op("overflow", 1'b0, 2'b00, 8'hEE);
    chk("overflow_fullflag", int'(full), 1);

    for (int i = 0; i < 60; i++) begin
      ro0 = ($urandom_range(0, 9) < 3) ? 2'b00 : 2'($urandom_range(1, 3));
      ro1 = ($urandom_range(0, 9) < 4) ? 2'b01 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        run_pair("rnd_pair", ro0, 8'($urandom), ro1, 8'($urandom));
      else
        model_op("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? ro0 : ro1, 8'($urandom));
    end

    // Reset asserted while a push sits in SETTLE.
    if (q.size() == 31) model_op("prep", 1'b1, 2'b01, 8'h00);
    wait_ready();
    req0 = 1'b1; op0 = 2'b00; din0 = 8'h77;
    @(posedge clk); #1;
    chk("midrst_issue_push", int'(stk_push), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    req0 = 1'b0;
    chk("midrst_outputs", int'({ack0, ack1, err0, err1, ready, stk_push, stk_pop, empty, full}), 0);
    chk("midrst_data", int'({rd_data, stk_din, 3'b000, depth}), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_ack", int'({ack0, err0}), 0);
    check_drain("drain2");
    model_op("post_push", 1'b0, 2'b00, 8'h3C);
    model_op("post_peek", 1'b1, 2'b10, 8'h00);
    model_op("post_pop", 1'b1, 2'b01, 8'h00);

    chk("iface_rules", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

endmodule
